// File: rtl/vip_matrix_3x3_gen.sv
// rtl/vip_matrix_3x3_gen.sv - 3x3 neighbourhood window builder behind the 8-bit line-shift RAM
// Aligns syncs to the RAM latency, shifts three row taps into a window and fills frame borders.
module vip_matrix_3x3_gen #(
    parameter logic [12:0] IMG_HDISP = 13'd640,
    parameter logic [11:0] IMG_VDISP = 12'd480,
    parameter logic [4:0]  DATA_W    = 5'd8,
    parameter int          LINE_LAT  = 3,
    parameter logic        BORDER    = 1'b1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] tap0,
    input  logic [DATA_W-1:0] tap1,
    input  logic [DATA_W-1:0] tap2,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);

    localparam int CW = (IMG_HDISP > 13'd1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW = (IMG_VDISP > 12'd1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 13'd1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 12'd1);

    logic                r_armed;
    logic [LINE_LAT-1:0] r_vs_d, r_hs_d, r_ce_d;
    logic                r_out_vsync, r_out_href, r_out_clken;
    logic [CW-1:0]       r_col_cnt;
    logic [RW-1:0]       r_row_cnt;
    logic [DATA_W-1:0]   r_win  [3][3];
    logic [DATA_W-1:0]   w_row  [3];
    logic [DATA_W-1:0]   w_next [3][3];
    logic                w_d_vsync, w_d_href, w_d_clken;
    logic                w_href_fall, w_vsync_rise;

    // After reset the input syncs are ignored until vsync has been seen low,
    // so a frame interrupted by reset is dropped and the next frame starts clean.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (!per_frame_vsync) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d      <= '0;
            r_hs_d      <= '0;
            r_ce_d      <= '0;
            r_out_vsync <= 1'b0;
            r_out_href  <= 1'b0;
            r_out_clken <= 1'b0;
        end else begin
            r_vs_d[0] <= per_frame_vsync & r_armed;
            r_hs_d[0] <= per_frame_href  & r_armed;
            r_ce_d[0] <= per_frame_clken & r_armed;
            for (int i = 1; i < LINE_LAT; i++) begin
                r_vs_d[i] <= r_vs_d[i-1];
                r_hs_d[i] <= r_hs_d[i-1];
                r_ce_d[i] <= r_ce_d[i-1];
            end
            r_out_vsync <= w_d_vsync;
            r_out_href  <= w_d_href;
            r_out_clken <= w_d_clken;
        end
    end

    assign w_d_vsync = r_vs_d[LINE_LAT-1];
    assign w_d_href  = r_hs_d[LINE_LAT-1];
    assign w_d_clken = r_ce_d[LINE_LAT-1];

    // The output sync registers double as the one-cycle history for edge detection.
    assign w_href_fall  = r_out_href & ~w_d_href;
    assign w_vsync_rise = w_d_vsync & ~r_out_vsync;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            if (!w_d_href) begin
                r_col_cnt <= '0;
            end else if (w_d_clken && (r_col_cnt != COL_MAX)) begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
            if (w_vsync_rise) begin
                r_row_cnt <= '0;
            end else if (w_href_fall && (r_row_cnt != ROW_MAX)) begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

    // Row fill first, then column fill on the already row-filled values.
    always_comb begin
        w_row[0] = tap1;
        w_row[1] = tap0;
        w_row[2] = tap2;
        if (r_row_cnt == '0) begin
            w_row[0] = BORDER ? tap2 : '0;
            w_row[1] = BORDER ? tap2 : '0;
        end else if (r_row_cnt == RW'(1)) begin
            w_row[0] = BORDER ? tap0 : '0;
        end
        for (int i = 0; i < 3; i++) begin
            w_next[i][2] = w_row[i];
            w_next[i][1] = r_win[i][2];
            w_next[i][0] = r_win[i][1];
            if (r_col_cnt == '0) begin
                w_next[i][1] = BORDER ? w_row[i] : '0;
                w_next[i][0] = BORDER ? w_row[i] : '0;
            end else if (r_col_cnt == CW'(1)) begin
                w_next[i][0] = BORDER ? r_win[i][2] : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_d_clken) begin
            r_win <= w_next;
        end
    end

    assign matrix_frame_vsync = r_out_vsync;
    assign matrix_frame_href  = r_out_href;
    assign matrix_frame_clken = r_out_clken;
    assign matrix_p11 = r_win[0][0];
    assign matrix_p12 = r_win[0][1];
    assign matrix_p13 = r_win[0][2];
    assign matrix_p21 = r_win[1][0];
    assign matrix_p22 = r_win[1][1];
    assign matrix_p23 = r_win[1][2];
    assign matrix_p31 = r_win[2][0];
    assign matrix_p32 = r_win[2][1];
    assign matrix_p33 = r_win[2][2];

endmodule

// File: tb/tb_vip_matrix_3x3_gen.sv
// tb/tb_vip_matrix_3x3_gen.sv - directed-vector bench for vip_matrix_3x3_gen
// Two instances on a 4x4 image: u_rep replicates borders, u_zero zero-fills with all-0xFF taps.
module tb_vip_matrix_3x3_gen;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs = 1'b0, hs = 1'b0, ce = 1'b0;
    logic [7:0] t0 = 8'h0, t1 = 8'h0, t2 = 8'h0;
    logic [7:0] ff_tap = 8'hFF;

    logic       a_vs, a_hs, a_ce, b_vs, b_hs, b_ce;
    logic [7:0] a_p11, a_p12, a_p13, a_p21, a_p22, a_p23, a_p31, a_p32, a_p33;
    logic [7:0] b_p11, b_p12, b_p13, b_p21, b_p22, b_p23, b_p31, b_p32, b_p33;

    int n_vec = 0;
    int n_err = 0;

    int h_ce [4];
    int h_r  [4];
    int h_c  [4];
    logic [71:0] win_a [6][4];
    logic [71:0] win_b [6][4];

    wire [71:0] w_a = {a_p11, a_p12, a_p13, a_p21, a_p22, a_p23, a_p31, a_p32, a_p33};
    wire [71:0] w_b = {b_p11, b_p12, b_p13, b_p21, b_p22, b_p23, b_p31, b_p32, b_p33};

    always #5 clock = ~clock;

    vip_matrix_3x3_gen #(.IMG_HDISP(13'd4), .IMG_VDISP(12'd4), .DATA_W(5'd8),
                         .LINE_LAT(3), .BORDER(1'b1)) u_rep (
        .clock(clock), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce),
        .tap0(t0), .tap1(t1), .tap2(t2),
        .matrix_frame_vsync(a_vs), .matrix_frame_href(a_hs), .matrix_frame_clken(a_ce),
        .matrix_p11(a_p11), .matrix_p12(a_p12), .matrix_p13(a_p13),
        .matrix_p21(a_p21), .matrix_p22(a_p22), .matrix_p23(a_p23),
        .matrix_p31(a_p31), .matrix_p32(a_p32), .matrix_p33(a_p33)
    );

    vip_matrix_3x3_gen #(.IMG_HDISP(13'd4), .IMG_VDISP(12'd4), .DATA_W(5'd8),
                         .LINE_LAT(3), .BORDER(1'b0)) u_zero (
        .clock(clock), .rst_n(rst_n),
        .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce),
        .tap0(ff_tap), .tap1(ff_tap), .tap2(ff_tap),
        .matrix_frame_vsync(b_vs), .matrix_frame_href(b_hs), .matrix_frame_clken(b_ce),
        .matrix_p11(b_p11), .matrix_p12(b_p12), .matrix_p13(b_p13),
        .matrix_p21(b_p21), .matrix_p22(b_p22), .matrix_p23(b_p23),
        .matrix_p31(b_p31), .matrix_p32(b_p32), .matrix_p33(b_p33)
    );

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    // One clock of stimulus; taps emulate a line RAM returning the pixel from three steps earlier.
    task automatic step(input logic v, input logic h, input logic e, input int r, input int c);
        for (int i = 3; i > 0; i--) begin
            h_ce[i] = h_ce[i-1];
            h_r[i]  = h_r[i-1];
            h_c[i]  = h_c[i-1];
        end
        h_ce[0] = int'(e);
        h_r[0]  = r;
        h_c[0]  = c;
        vs = v; hs = h; ce = e;
        if (h_ce[3] != 0) begin
            t2 = pix(h_r[3], h_c[3]);
            t0 = (h_r[3] >= 1) ? pix(h_r[3] - 1, h_c[3]) : 8'hEE;
            t1 = (h_r[3] >= 2) ? pix(h_r[3] - 2, h_c[3]) : 8'hEE;
        end else begin
            t0 = 8'h5A; t1 = 8'h5A; t2 = 8'h5A;
        end
        @(posedge clock);
        #1;
        if (h_r[3] >= 0 && h_r[3] < 6 && h_c[3] >= 0 && h_c[3] < 4) begin
            if (a_ce) win_a[h_r[3]][h_c[3]] = w_a;
            if (b_ce) win_b[h_r[3]][h_c[3]] = w_b;
        end
    endtask

    task automatic clear_wins();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_a[r][c] = {9{8'hAB}};
                win_b[r][c] = {9{8'hAB}};
            end
        end
    endtask

    task automatic drive_frame(input int nlines);
        repeat (3) step(1'b0, 1'b0, 1'b0, -1, 0);
        repeat (2) step(1'b1, 1'b0, 1'b0, -1, 0);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b1, l, c);
            repeat (5) step(1'b1, 1'b0, 1'b0, -1, 0);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, -1, 0);
    endtask

    task automatic test_reset();
        logic [74:0] got;
        #1;
        got = {a_vs, a_hs, a_ce, w_a};
        n_vec++;
        if (got !== 75'd0) begin
            n_err++;
            $display("FAIL reset_initial: got %h expected 0", got);
        end
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, -1, 0);
        repeat (2) step(1'b1, 1'b0, 1'b0, -1, 0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b1, 0, c);
        n_vec++;
        if (a_vs !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_vsync: got %b expected 1", a_vs);
        end
        rst_n = 1'b0;
        #1;
        got = {a_vs, a_hs, a_ce, w_a};
        n_vec++;
        if (got !== 75'd0 || {b_vs, b_hs, b_ce, w_b} !== 75'd0) begin
            n_err++;
            $display("FAIL reset_midframe: got %h / %h expected 0", got, {b_vs, b_hs, b_ce, w_b});
        end
        step(1'b1, 1'b1, 1'b1, -1, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, (k % 2) == 0, -1, 0);
            n_vec++;
            if ({a_vs, a_hs, a_ce} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_idle_syncs k=%0d: got %b expected 000", k, {a_vs, a_hs, a_ce});
            end
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, -1, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, -1, 0);
            n_vec++;
            if (a_vs !== (k >= 3)) begin
                n_err++;
                $display("FAIL restart_vsync k=%0d: got %b expected %b", k, a_vs, (k >= 3));
            end
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, -1, 0);
    endtask

    task automatic test_latency();
        step(1'b0, 1'b0, 1'b1, -1, 0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step(1'b0, 1'b0, 1'b0, -1, 0);
            n_vec++;
            if (a_ce !== (k == 3)) begin
                n_err++;
                $display("FAIL latency edge=%0d: got %b expected %b", k + 1, a_ce, (k == 3));
            end
        end
    endtask

    task automatic test_interior();
        clear_wins();
        drive_frame(4);
        n_vec++;
        if (win_a[2][3] !== 72'h01_02_03_11_12_13_21_22_23) begin
            n_err++;
            $display("FAIL interior_r2c3: got %h expected 010203111213212223", win_a[2][3]);
        end
        n_vec++;
        if (win_a[3][3] !== 72'h11_12_13_21_22_23_31_32_33) begin
            n_err++;
            $display("FAIL interior_r3c3: got %h expected 111213212223313233", win_a[3][3]);
        end
        n_vec++;
        if (win_a[1][2] !== 72'h00_01_02_00_01_02_10_11_12) begin
            n_err++;
            $display("FAIL row1_fill_r1c2: got %h expected 000102000102101112", win_a[1][2]);
        end
        n_vec++;
        if (win_a[2][0] !== 72'h00_00_00_10_10_10_20_20_20) begin
            n_err++;
            $display("FAIL col0_fill_r2c0: got %h expected 000000101010202020", win_a[2][0]);
        end
    endtask

    task automatic test_replicate();
        n_vec++;
        if (win_a[0][0] !== 72'h0) begin
            n_err++;
            $display("FAIL replicate_r0c0: got %h expected 0", win_a[0][0]);
        end
        n_vec++;
        if (win_a[0][1] !== 72'h00_00_01_00_00_01_00_00_01) begin
            n_err++;
            $display("FAIL replicate_r0c1: got %h expected 000001000001000001", win_a[0][1]);
        end
        n_vec++;
        if (win_a[0][3] !== 72'h01_02_03_01_02_03_01_02_03) begin
            n_err++;
            $display("FAIL replicate_r0c3: got %h expected 010203010203010203", win_a[0][3]);
        end
    endtask

    task automatic test_zero_fill();
        n_vec++;
        if (win_b[0][0] !== 72'h00_00_00_00_00_00_00_00_FF) begin
            n_err++;
            $display("FAIL zero_r0c0: got %h expected 0000000000000000ff", win_b[0][0]);
        end
        n_vec++;
        if (win_b[1][1] !== 72'h00_00_00_00_FF_FF_00_FF_FF) begin
            n_err++;
            $display("FAIL zero_r1c1: got %h expected 00000000ffff00ffff", win_b[1][1]);
        end
        n_vec++;
        if (win_b[2][2] !== {9{8'hFF}}) begin
            n_err++;
            $display("FAIL zero_r2c2: got %h expected all ff", win_b[2][2]);
        end
    endtask

    task automatic test_gaps();
        logic [71:0] prev;
        int holds;
        clear_wins();
        holds = 0;
        repeat (3) step(1'b0, 1'b0, 1'b0, -1, 0);
        repeat (2) step(1'b1, 1'b0, 1'b0, -1, 0);
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < 4; c++) begin
                for (int g = 0; g < 2; g++) begin
                    if (g == 0 && c == 0) continue;
                    prev = w_a;
                    if (g == 0) step(1'b1, 1'b1, 1'b0, -1, 0);
                    else        step(1'b1, 1'b1, 1'b1, l, c);
                    if (a_hs && !a_ce) begin
                        holds++;
                        n_vec++;
                        if (w_a !== prev) begin
                            n_err++;
                            $display("FAIL gap_hold line=%0d: got %h expected %h", l, w_a, prev);
                        end
                    end
                end
            end
            repeat (5) step(1'b1, 1'b0, 1'b0, -1, 0);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, -1, 0);
        n_vec++;
        if (holds < 12) begin
            n_err++;
            $display("FAIL gap_cycles_seen: got %0d expected >= 12", holds);
        end
        n_vec++;
        if (win_a[2][3] !== 72'h01_02_03_11_12_13_21_22_23) begin
            n_err++;
            $display("FAIL gap_r2c3: got %h expected 010203111213212223", win_a[2][3]);
        end
        n_vec++;
        if (win_a[4][2] !== 72'h20_21_22_30_31_32_40_41_42) begin
            n_err++;
            $display("FAIL row_sat_r4c2: got %h expected 202122303132404142", win_a[4][2]);
        end
        n_vec++;
        if (win_a[5][3] !== 72'h31_32_33_41_42_43_51_52_53) begin
            n_err++;
            $display("FAIL row_sat_r5c3: got %h expected 313233414243515253", win_a[5][3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            h_ce[i] = 0; h_r[i] = -1; h_c[i] = 0;
        end
        test_reset();
        test_latency();
        test_interior();
        test_replicate();
        test_zero_fill();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
